// File: rtl/glitch_filter_pkg.sv
// Shared defaults, per-channel action type and parameter derivations
// for the multi-channel input glitch filter.
package glitch_filter_pkg;

    localparam int GF_CLK_FREQ_DEF    = 50000000;
    localparam int GF_SAMPLE_FREQ_DEF = 60000;
    localparam int GF_DEPTH_DEF       = 4;
    localparam int GF_CHANNELS_DEF    = 2;

    // What one channel does to its counter and accepted level in a cycle.
    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,
        ACT_CLEAR  = 3'd1,
        ACT_COUNT  = 3'd2,
        ACT_ACCEPT = 3'd3,
        ACT_FOLLOW = 3'd4
    } chan_act_e;

    function automatic int gf_div(input int clk_freq, input int sample_freq);
        int div_v;
        if (sample_freq > 0) begin
            div_v = clk_freq / sample_freq;
        end else begin
            div_v = 1;
        end
        if (div_v < 1) begin
            div_v = 1;
        end else begin
            div_v = div_v;
        end
        return div_v;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int gf_width(input int n);
        int w_v;
        if (n > 1) begin
            w_v = $clog2(n);
        end else begin
            w_v = 1;
        end
        return w_v;
    endfunction

    function automatic chan_act_e gf_chan_act(
        input logic tick_en,
        input logic bypass,
        input logic agree,
        input logic at_max
    );
        chan_act_e act_v;
        if (bypass) begin
            act_v = ACT_FOLLOW;
        end else if (!tick_en) begin
            act_v = ACT_HOLD;
        end else if (agree) begin
            act_v = ACT_CLEAR;
        end else if (at_max) begin
            act_v = ACT_ACCEPT;
        end else begin
            act_v = ACT_COUNT;
        end
        return act_v;
    endfunction

endpackage

// File: rtl/glitch_filter_chan.sv
// One filtered input line: 2-flop synchroniser, agreement counter clocked
// by the shared sample tick, accepted level and registered edge pulses.
module glitch_filter_chan
    import glitch_filter_pkg::*;
#(
    parameter int DEPTH = GF_DEPTH_DEF
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic tick_en,
    input  logic bypass,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic pending
);

    localparam int              CNT_W    = gf_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             meta_r;
    logic             sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_r;
    logic             level_nxt_s;
    logic             rise_r;
    logic             fall_r;
    chan_act_e        act_s;

    // Bring the asynchronous input into the iCLK domain.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
        end
    end

    // Decide this cycle's action from tick, mode and counter position.
    always_comb begin
        act_s = gf_chan_act(tick_en, bypass, (sync_r == level_r), (cnt_r == CNT_MAX));
    end

    // Next counter and level; bypass and acceptance both return to STABLE.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        case (act_s)
            ACT_HOLD: begin
                cnt_nxt_s   = cnt_r;
                level_nxt_s = level_r;
            end
            ACT_CLEAR: begin
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = level_r;
            end
            ACT_COUNT: begin
                cnt_nxt_s   = cnt_r + CNT_ONE;
                level_nxt_s = level_r;
            end
            ACT_ACCEPT, ACT_FOLLOW: begin
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = sync_r;
            end
            default: begin
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = level_r;
            end
        endcase
    end

    // Filter state and edge pulses; a pulse marks the first cycle of a new level.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= level_nxt_s & ~level_r;
            fall_r  <= ~level_nxt_s & level_r;
        end
    end

    assign level   = level_r;
    assign rise    = rise_r;
    assign fall    = fall_r;
    assign pending = (cnt_r != CNT_ZERO);

endmodule

// File: rtl/glitch_filter_checker.sv
// Run-time invariants of the filter outputs; carries no functional logic.
module glitch_filter_checker #(
    parameter int CHANNELS = 2
) (
    input logic                iCLK,
    input logic                iRST,
    input logic                bypass,
    input logic [CHANNELS-1:0] level,
    input logic [CHANNELS-1:0] rise,
    input logic [CHANNELS-1:0] fall,
    input logic [CHANNELS-1:0] pending
);

    localparam logic [CHANNELS-1:0] NONE = {CHANNELS{1'b0}};

    a_excl: assert property (@(posedge iCLK) disable iff (iRST) (rise & fall) == NONE);
    a_rise: assert property (@(posedge iCLK) disable iff (iRST) (rise & ~level) == NONE);
    a_fall: assert property (@(posedge iCLK) disable iff (iRST) (fall & level) == NONE);
    a_byp:  assert property (@(posedge iCLK) disable iff (iRST) bypass |=> (pending == NONE));

endmodule

// File: rtl/glitch_filter.sv
// Multi-channel glitch filter: shared sample-tick prescaler used purely as a
// clock enable, plus one independent filter channel per input line.
module glitch_filter
    import glitch_filter_pkg::*;
#(
    parameter int CLK_FREQ    = GF_CLK_FREQ_DEF,
    parameter int SAMPLE_FREQ = GF_SAMPLE_FREQ_DEF,
    parameter int CHANNELS    = GF_CHANNELS_DEF,
    parameter int DEPTH       = GF_DEPTH_DEF
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [CHANNELS-1:0] iDATA,
    input  logic                iBYPASS,
    output logic [CHANNELS-1:0] oDATA,
    output logic [CHANNELS-1:0] oRISE,
    output logic [CHANNELS-1:0] oFALL,
    output logic                oTICK
);

    localparam int               DIV      = gf_div(CLK_FREQ, SAMPLE_FREQ);
    localparam int               PRE_W    = gf_width(DIV);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0]    pre_cnt_r;
    logic [PRE_W-1:0]    pre_nxt_s;
    logic                tick_r;
    logic [CHANNELS-1:0] pending_s;

    // Prescaler next count, wrapping to zero after DIV-1.
    always_comb begin
        if (pre_cnt_r == PRE_MAX) begin
            pre_nxt_s = PRE_ZERO;
        end else begin
            pre_nxt_s = pre_cnt_r + PRE_ONE;
        end
    end

    // Prescaler and tick strobe; the strobe is high while the count sits at DIV-1.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pre_cnt_r <= PRE_ZERO;
            tick_r    <= 1'b0;
        end else begin
            pre_cnt_r <= pre_nxt_s;
            tick_r    <= (pre_nxt_s == PRE_MAX);
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        glitch_filter_chan #(
            .DEPTH(DEPTH)
        ) u_chan (
            .iCLK   (iCLK),
            .iRST   (iRST),
            .tick_en(tick_r),
            .bypass (iBYPASS),
            .din    (iDATA[ch]),
            .level  (oDATA[ch]),
            .rise   (oRISE[ch]),
            .fall   (oFALL[ch]),
            .pending(pending_s[ch])
        );
    end

    assign oTICK = tick_r;

    glitch_filter_checker #(
        .CHANNELS(CHANNELS)
    ) u_checker (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .bypass (iBYPASS),
        .level  (oDATA),
        .rise   (oRISE),
        .fall   (oFALL),
        .pending(pending_s)
    );

endmodule

// File: tb/tb_glitch_filter.sv
// Bench for glitch_filter: per-cycle scoreboard against a reference model
// plus directed timing checks on reset, glitches, bypass and the prescaler.
module tb_glitch_filter;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       byp;
    logic [1:0] din;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       tick;

    always #5 clk = ~clk;

    glitch_filter #(
        .CLK_FREQ   (1000),
        .SAMPLE_FREQ(100),
        .CHANNELS   (2),
        .DEPTH      (DEPTH)
    ) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iDATA  (din),
        .iBYPASS(byp),
        .oDATA  (dout),
        .oRISE  (rise),
        .oFALL  (fall),
        .oTICK  (tick)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: expected {level, rise, fall, tick} after every edge.
    logic [6:0] exp_q[$];
    logic [1:0] h1, h2, m_lvl, m_rise, m_fall, nl;
    int         m_pend[2];
    int         m_pre;
    logic       m_tick;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                h1 = 2'b00; h2 = 2'b00; m_lvl = 2'b00; m_rise = 2'b00; m_fall = 2'b00;
                m_pend[0] = 0; m_pend[1] = 0; m_pre = 0; m_tick = 1'b0;
            end else begin
                nl = m_lvl;
                for (int c = 0; c < 2; c++) begin
                    if (byp) begin
                        nl[c] = h2[c];
                        m_pend[c] = 0;
                    end else if (m_tick) begin
                        if (h2[c] == m_lvl[c]) begin
                            m_pend[c] = 0;
                        end else begin
                            m_pend[c]++;
                            if (m_pend[c] == DEPTH) begin
                                nl[c] = h2[c];
                                m_pend[c] = 0;
                            end
                        end
                    end
                end
                m_rise = nl & ~m_lvl;
                m_fall = m_lvl & ~nl;
                m_lvl  = nl;
                h2 = h1;
                h1 = din;
                m_pre  = (m_pre + 1) % DIV;
                m_tick = (m_pre == DIV - 1);
            end
            exp_q.push_back({m_lvl, m_rise, m_fall, m_tick});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                chk("model", {25'd0, dout, rise, fall, tick}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    int t0, t1, nr0, nr1, nf, ntick, nwide, idx;
    logic prev_tick;

    initial begin
        rst = 1'b1; byp = 1'b0; din = 2'b11;
        // Reset held three cycles with both inputs high.
        repeat (3) begin
            @(negedge clk);
            chk("rst_out", {25'd0, dout, rise, fall, tick}, 32'd0);
        end
        rst = 1'b0;
        t0 = -1; t1 = -1; nr0 = 0; nr1 = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rise[0]) begin nr0++; t0 = i; end
            if (rise[1]) begin nr1++; t1 = i; end
        end
        chk("rel_lvl", {30'd0, dout}, 32'd3);
        chk("rel_rise0_n", nr0, 32'd1);
        chk("rel_rise1_n", nr1, 32'd1);
        chk("rel_rise0_t", t0, 32'd39);
        chk("rel_rise1_t", t1, 32'd39);

        // 25-cycle high pulse on a stable-low ch0 must be swallowed.
        din[0] = 1'b0;
        repeat (60) @(negedge clk);
        chk("ch0_low", {31'd0, dout[0]}, 32'd0);
        nr0 = 0;
        din[0] = 1'b1;
        for (int i = 0; i < 85; i++) begin
            @(negedge clk);
            if (i == 24) din[0] = 1'b0;
            if (rise[0] | fall[0] | dout[0]) nr0++;
        end
        chk("glitch25", nr0, 32'd0);

        // ch1 toggling with a half-period of one tick never settles.
        nr1 = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 10 == 0) din[1] = ~din[1];
            @(negedge clk);
            if (rise[1] | fall[1]) nr1++;
            if (dout[1] !== 1'b1) nr1++;
        end
        chk("toggle_quiet", nr1, 32'd0);

        // Bypass: 3-cycle follow latency, then release without pulses.
        repeat (20) @(negedge clk);
        byp = 1'b1;
        repeat (5) @(negedge clk);
        din[1] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("byp_lvl", {31'd0, dout[1]}, (i >= 3) ? 32'd0 : 32'd1);
            chk("byp_fall", {31'd0, fall[1]}, (i == 3) ? 32'd1 : 32'd0);
        end
        byp = 1'b0;
        nf = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((rise | fall) != 2'b00 || dout != 2'b00) nf++;
        end
        chk("byp_release", nf, 32'd0);

        // Reset after three counted ticks discards the partial count.
        din[0] = 1'b1;
        repeat (2) @(negedge clk);
        nf = 0;
        for (int i = 0; i < 40 && nf < 3; i++) begin
            @(negedge clk);
            if (tick) nf++;
        end
        chk("pend_ticks", nf, 32'd3);
        @(negedge clk);
        chk("pend_no_accept", {31'd0, dout[0]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out", {25'd0, dout, rise, fall, tick}, 32'd0);
        rst = 1'b0;
        t0 = -1; nf = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rise[0] && t0 < 0) t0 = i;
            if (tick && t0 < 0) nf++;
        end
        chk("rst_mid_t", t0, 32'd39);
        chk("rst_mid_ticks", nf, 32'd4);

        // Prescaler over 1000 cycles with random traffic on the inputs.
        t0 = -1; ntick = 0; nwide = 0; prev_tick = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if ($urandom_range(7, 0) == 0) begin
                idx = $urandom_range(1, 0);
                din[idx] = ~din[idx];
            end
            if ($urandom_range(63, 0) == 0) byp = ~byp;
            @(negedge clk);
            if (tick) begin
                if (t0 >= 0) chk("tick_period", cyc - t0, DIV);
                t0 = cyc;
                ntick++;
                if (prev_tick) nwide++;
            end
            prev_tick = tick;
        end
        chk("tick_count", ntick, 32'd100);
        chk("tick_width", nwide, 32'd0);

        // Random traffic including slow steps and occasional resets.
        byp = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(15, 0) == 0) din = 2'($urandom_range(3, 0));
            if ($urandom_range(127, 0) == 0) byp = ~byp;
            rst = ($urandom_range(255, 0) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/glitch_filter.md
GLITCH_FILTER -- requirements
Module: glitch_filter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning iCLK frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_FREQ, default 60000, meaning filter sample-tick rate in Hz.
REQ-003 SHALL have parameter CHANNELS, default 2, meaning number of independent input lines, 1..32.
REQ-004 SHALL have parameter DEPTH, default 4, meaning consecutive agreeing samples needed to accept a new level, 1..256.
REQ-005 SHALL have port iCLK  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port iRST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port iDATA  input  CHANNELS  raw asynchronous inputs, e.g. encoder A/B.
REQ-008 SHALL have port iBYPASS  input  1  mode select: 1 = synchronise only, no filtering.
REQ-009 SHALL have port oDATA  output  CHANNELS  filtered levels.
REQ-010 SHALL have port oRISE  output  CHANNELS  one-cycle pulse per accepted 0->1 change.
REQ-011 SHALL have port oFALL  output  CHANNELS  one-cycle pulse per accepted 1->0 change.
REQ-012 SHALL have port oTICK  output  1  sample-tick strobe, for debug.

Function
REQ-013 Prescaler SHALL count 0..DIV-1, DIV = CLK_FREQ/SAMPLE_FREQ (integer, minimum 1); oTICK high exactly one cycle when count = DIV-1, then wrap to 0; DIV=1 gives tick every cycle.
REQ-014 No derived clock SHALL exist; tick used only as clock enable.
REQ-015 Each iDATA bit SHALL pass a 2-flop synchroniser before any use; sync latency 2 cycles.
REQ-016 Per channel, counter cnt, width clog2(DEPTH) (min 1), states STABLE (cnt=0) and PENDING (cnt>0).
REQ-017 On tick, sync = oDATA: cnt <= 0 (PENDING -> STABLE, glitch discarded).
REQ-018 On tick, sync != oDATA and cnt < DEPTH-1: cnt <= cnt+1 (STABLE -> PENDING).
REQ-019 On tick, sync != oDATA and cnt = DEPTH-1: oDATA <= sync, cnt <= 0; DEPTH=1 accepts on first disagreeing tick.
REQ-020 No tick: cnt and oDATA hold.
REQ-021 oRISE/oFALL SHALL be high exactly in the first cycle oDATA shows the new value, never both, never otherwise.
REQ-022 Worst-case latency input step -> oDATA: 2 + DEPTH*DIV cycles; glitches shorter than (DEPTH-1)*DIV cycles never reach oDATA.
REQ-023 iBYPASS=1: oDATA follows synchroniser output each cycle (latency 3 cycles from iDATA incl. output register), edge pulses still generated, all cnt forced 0.
REQ-024 iBYPASS 1->0: filtering restarts from STABLE with current oDATA; no spurious pulse.
REQ-025 Channels SHALL be fully independent; simultaneous changes on several channels update in the same cycle.

Reset
REQ-026 iRST=1 at a clock edge SHALL clear prescaler, synchronisers, cnt, oDATA, oRISE, oFALL, oTICK to 0; overrides tick and iBYPASS.
REQ-027 Reset mid-PENDING discards partial count; after release a full DEPTH ticks are again required.
REQ-028 First tick after release SHALL occur DIV cycles after the last reset cycle.

Structure
REQ-029 Package glitch_filter_pkg SHALL hold default CLK_FREQ, SAMPLE_FREQ, DEPTH constants and the DIV/counter-width derivation functions.
REQ-030 Sub-module glitch_filter_chan (synchroniser + counter + edge pulses for one line) SHALL be instantiated CHANNELS times by generate; prescaler stays in top.

Verification (CLK_FREQ=1000, SAMPLE_FREQ=100 -> DIV=10, DEPTH=4, CHANNELS=2)
REQ-031 iRST high 3 cycles with iDATA=2'b11 -> outputs all 0 during reset; after release oDATA=2'b11 within 2+40 cycles, one oRISE pulse per bit, same cycle.
REQ-032 Ch0 stable 0, high pulse lasting 25 cycles -> oDATA[0] stays 0, no oRISE/oFALL.
REQ-033 Ch1 toggling every 10 cycles for 200 cycles -> oDATA[1] never changes, no pulses.
REQ-034 iBYPASS=1, ch1 1->0 step -> oDATA[1]=0 and one-cycle oFALL[1] 3 cycles later; bypass released -> no pulse.
REQ-035 Ch0 step 0->1, iRST for 1 cycle after 3 ticks -> oDATA[0]=0; accepted only after 4 further ticks.
REQ-036 Prescaler check: oTICK period exactly 10 cycles, one cycle wide, over 100 ticks.
